// File: rtl/key_sync_debounce_if.sv
// key_sync_debounce_if
// Bundles the key-conditioner signals: raw keys in, debounced level and
// one-cycle edge pulses out. The release pulse exists only when
// KEY_SYNC_RELEASE_PULSE_EN is defined.
//   master : the conditioner (consumes key, drives level/pulses)
//   slave  : the board/consumer side (drives key, observes level/pulses)

interface key_sync_debounce_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] key;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press_pulse;
`ifdef KEY_SYNC_RELEASE_PULSE_EN
  logic [CHANNELS-1:0] release_pulse;
`endif

`ifdef KEY_SYNC_RELEASE_PULSE_EN
  modport master (
    input  key,
    output level,
    output press_pulse,
    output release_pulse
  );

  modport slave (
    output key,
    input  level,
    input  press_pulse,
    input  release_pulse
  );
`else
  modport master (
    input  key,
    output level,
    output press_pulse
  );

  modport slave (
    output key,
    input  level,
    input  press_pulse
  );
`endif

endinterface

// File: rtl/key_sync_debounce.sv
// key_sync_debounce
// Multi-channel pushbutton conditioner: polarity fix, SYNC_STAGES-deep
// synchroniser, per-channel debounce counter and registered edge pulses.
// Optional feature macro: KEY_SYNC_RELEASE_PULSE_EN adds the one-cycle
// release pulse and its flops; without it only level and press exist.

module key_sync_debounce #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int INVERT          = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_sync_debounce_if.master  bus
);

  // Counter must hold values up to DEBOUNCE_CYCLES-1; sized as clog2(N+1).
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CHANNELS-1:0] CH_ZERO = {CHANNELS{1'b0}};

  // Synchroniser chain, stage 0 is fed by the (possibly inverted) raw key.
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0] stable_s;

  // Debounce state and registered outputs.
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] press_q;
  logic [CHANNELS-1:0] press_d;
`ifdef KEY_SYNC_RELEASE_PULSE_EN
  logic [CHANNELS-1:0] release_q;
  logic [CHANNELS-1:0] release_d;
`endif

  // Inversion sits in front of the first flop so that a key held pressed
  // through reset reads as "released" (0) at reset and later gives a Press.
  // Next-state for the synchroniser shift chain.
  always_comb begin
    for (int k = 0; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k];
    end
    if (INVERT != 0) begin
      sync_d[0] = ~bus.key;
    end else begin
      sync_d[0] = bus.key;
    end
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Synchroniser flops; no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= CH_ZERO;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign stable_s = sync_q[SYNC_STAGES-1];

  // Debounce: count consecutive cycles of disagreement with the current
  // level; any return to the old value restarts the count. On the
  // DEBOUNCE_CYCLES-th disagreeing cycle the level flips and the matching
  // edge pulse is registered alongside it, so the pulse coincides with the
  // first cycle the new level is visible.
  always_comb begin
    level_d = level_q;
    press_d = CH_ZERO;
`ifdef KEY_SYNC_RELEASE_PULSE_EN
    release_d = CH_ZERO;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (stable_s[i] == level_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]   = CNT_ZERO;
        level_d[i] = stable_s[i];
        press_d[i] = stable_s[i];
`ifdef KEY_SYNC_RELEASE_PULSE_EN
        release_d[i] = ~stable_s[i];
`endif
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debounce counters, level and pulse registers; reset discards any
  // count in progress and restarts every channel from level 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      level_q <= CH_ZERO;
      press_q <= CH_ZERO;
`ifdef KEY_SYNC_RELEASE_PULSE_EN
      release_q <= CH_ZERO;
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q <= level_d;
      press_q <= press_d;
`ifdef KEY_SYNC_RELEASE_PULSE_EN
      release_q <= release_d;
`endif
    end
  end

  // All outputs come straight from flops.
  assign bus.level       = level_q;
  assign bus.press_pulse = press_q;
`ifdef KEY_SYNC_RELEASE_PULSE_EN
  assign bus.release_pulse = release_q;
`endif

endmodule
